// File: rtl/if_pkg.sv
// Shared types and default constants for the instruction-fetch stage.
package if_pkg;

   // Fetch FSM: FETCH issues normally, WAIT means the last request had no data.
   typedef enum logic [0:0] {
      FETCH = 1'b0,
      WAIT  = 1'b1
   } if_state_e;

   localparam int unsigned INSN_W          = 32;
   localparam logic [63:0] DEF_RESET_VEC   = 64'd64;
   localparam logic [31:0] DEF_BUBBLE_WORD = 32'h0000_0000;

endpackage : if_pkg

// File: rtl/if_pc_gen.sv
// PC register and next-PC selection (reset / redirect / hold / +4).
// Optional IF_MISALIGN_TRAP_EN: word-align redirect targets and flag misaligned ones.
module if_pc_gen
   import if_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC)
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            advance_i,
   output logic [XLEN-1:0] pc_o
`ifdef IF_MISALIGN_TRAP_EN
   ,
   output logic            misalign_o
`endif
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] target;

`ifdef IF_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;

   // Force word alignment; the flag is only raised by the redirect edge itself.
   assign target     = redirect_pc_i & ~XLEN'(3);
   assign misalign_d = redirect_i & (|redirect_pc_i[1:0]);
   assign misalign_o = misalign_q;
`else
   assign target = redirect_pc_i;
`endif

   // Next PC: redirect wins, otherwise +4 on advance (wraps modulo 2^XLEN), else hold.
   always_comb begin
      pc_d = pc_q;
      if (redirect_i) begin
         pc_d = target;
      end else if (advance_i) begin
         pc_d = pc_q + XLEN'(4);
      end
   end

   // PC register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pc_q <= RESET_VEC;
      end else begin
         pc_q <= pc_d;
      end
   end

`ifdef IF_MISALIGN_TRAP_EN
   // One-cycle misalignment pulse register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end
`endif

   assign pc_o = pc_q;

endmodule : if_pc_gen

// File: rtl/if_stage_param.sv
// Instruction-fetch stage: fetch FSM, pipe register, PC generator instance.
// Optional IF_MISALIGN_TRAP_EN adds the misalign output.
module if_stage_param
   import if_pkg::*;
#(
   parameter int unsigned       XLEN        = 32,
   parameter logic [XLEN-1:0]   RESET_VEC   = XLEN'(DEF_RESET_VEC),
   parameter logic [INSN_W-1:0] BUBBLE_WORD = DEF_BUBBLE_WORD
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic [INSN_W-1:0] imem_data,
   input  logic              imem_valid,
   output logic              pipe_valid,
   output logic [XLEN-1:0]   pipe_pc,
   output logic [XLEN-1:0]   pipe_pc4,
   output logic [INSN_W-1:0] pipe_data
`ifdef IF_MISALIGN_TRAP_EN
   ,
   output logic              misalign
`endif
);

   if_state_e         state_q, state_d;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   pc_plus4;
   logic              advance;

   logic              pipe_valid_q, pipe_valid_d;
   logic [XLEN-1:0]   pipe_pc_q, pipe_pc_d;
   logic [XLEN-1:0]   pipe_pc4_q, pipe_pc4_d;
   logic [INSN_W-1:0] pipe_data_q, pipe_data_d;

   assign advance  = imem_valid & ~stall;
   assign pc_plus4 = pc + XLEN'(4);

   if_pc_gen #(
      .XLEN      (XLEN),
      .RESET_VEC (RESET_VEC)
   ) u_pc_gen (
      .clk_i         (clk),
      .reset_i       (reset),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .advance_i     (advance),
      .pc_o          (pc)
`ifdef IF_MISALIGN_TRAP_EN
      ,
      .misalign_o    (misalign)
`endif
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: redirect restarts, stall holds, missing data parks in WAIT.
   always_comb begin
      state_d = state_q;
      if (redirect) begin
         state_d = FETCH;
      end else if (stall) begin
         state_d = state_q;
      end else if (!imem_valid) begin
         state_d = WAIT;
      end else begin
         state_d = FETCH;
      end
   end

   // Outputs: fetch request and next pipe-register contents (default hold).
   always_comb begin
      imem_req     = ~reset;
      pipe_valid_d = pipe_valid_q;
      pipe_pc_d    = pipe_pc_q;
      pipe_pc4_d   = pipe_pc4_q;
      pipe_data_d  = pipe_data_q;
      if (redirect) begin
         pipe_valid_d = 1'b0;
         pipe_pc_d    = pc;
         pipe_pc4_d   = pc_plus4;
         pipe_data_d  = BUBBLE_WORD;
      end else if (stall) begin
         pipe_valid_d = pipe_valid_q;
      end else if (!imem_valid) begin
         pipe_valid_d = 1'b0;
         pipe_data_d  = BUBBLE_WORD;
      end else begin
         pipe_valid_d = 1'b1;
         pipe_pc_d    = pc;
         pipe_pc4_d   = pc_plus4;
         pipe_data_d  = imem_data;
      end
   end

   // Pipe registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_valid_q <= 1'b0;
         pipe_pc_q    <= '0;
         pipe_pc4_q   <= '0;
         pipe_data_q  <= '0;
      end else begin
         pipe_valid_q <= pipe_valid_d;
         pipe_pc_q    <= pipe_pc_d;
         pipe_pc4_q   <= pipe_pc4_d;
         pipe_data_q  <= pipe_data_d;
      end
   end

   assign imem_addr  = pc;
   assign pipe_valid = pipe_valid_q;
   assign pipe_pc    = pipe_pc_q;
   assign pipe_pc4   = pipe_pc4_q;
   assign pipe_data  = pipe_data_q;

endmodule : if_stage_param
